// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// APB initiator. Takes one request at a time from a valid/ready port and runs
// it as an APB SETUP/ACCESS transfer. Waits for PREADY, returns PRDATA and
// PSLVERR as a one-cycle response pulse, and gives up on a slave that holds
// PREADY low for TIMEOUT_CYCLES access cycles (0 disables the timeout).

module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // core-side request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // core-side response port
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB initiator port
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // Counter is wide enough to hold TIMEOUT_CYCLES itself.
  localparam int              CNT_W         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN    = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_inc_s;
  logic             timeout_hit_s;

  // Ready only in IDLE, and forced low for as long as reset is held.
  assign req_ready = (state_r == ST_IDLE) & ~rst;

  // Timeout fires on the wait cycle that would bring the count to the limit.
  always_comb begin
    wait_cnt_inc_s = wait_cnt_r + CNT_W'(1);
    if (TIMEOUT_EN && (wait_cnt_inc_s == TIMEOUT_LIMIT)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Transfer FSM: IDLE -> SETUP -> ACCESS -> RESP, all APB and response outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= '0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            // Address/data/direction stay frozen until the next accept.
            PWRITE     <= req_write;
            PADDR      <= req_addr;
            PWDATA     <= req_wdata;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            wait_cnt_r <= '0;
            state_r    <= ST_SETUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SETUP: begin
          PENABLE <= 1'b1;
          state_r <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            // A ready slave wins even on the cycle the timeout would fire.
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            state_r     <= ST_RESP;
          end else if (timeout_hit_s) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_inc_s;
            state_r    <= ST_ACCESS;
          end
        end

        ST_RESP: begin
          rsp_valid   <= 1'b0;
          rsp_rdata   <= '0;
          rsp_err     <= 1'b0;
          rsp_timeout <= 1'b0;
          state_r     <= ST_IDLE;
        end

        default: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed bench for the APB initiator: plain write, read with wait states,
// timeout abort, slave error, back-to-back requests and reset mid-transfer.

module tb_apb_master_bridge;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transfer: slave holds PREADY low for 'waits' ACCESS cycles, then raises it.
  // PSLVERR is err_wait while PREADY=0 and err_rdy when PREADY=1.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rd,
                          input logic err_rdy, input logic err_wait,
                          output int acc_cycles, output logic [31:0] r_rdata,
                          output logic r_err, output logic r_to);
    logic got;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = rd;
    check("ready_before_accept", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    check("setup_psel", PSEL, 1'b1);
    check("setup_penable", PENABLE, 1'b0);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_req_ready", req_ready, 1'b0);
    acc_cycles = 0; got = 1'b0;
    r_rdata = '0; r_err = 1'b0; r_to = 1'b0;
    step();
    for (int i = 0; i < 40 && !got; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
      end else begin
        if (PSEL && PENABLE) acc_cycles++;
        if (acc_cycles == 1) begin
          check("access_paddr", PADDR, addr);
          check("access_pwrite", PWRITE, wr);
          if (wr) check("access_pwdata", PWDATA, wdata);
        end
        PREADY  = (acc_cycles > waits);
        PSLVERR = PREADY ? err_rdy : err_wait;
        step();
      end
    end
    if (!got) check("rsp_valid_within_bound", 1'b0, 1'b1);
    PREADY = 1'b0; PSLVERR = 1'b0;
    check("resp_psel_low", PSEL, 1'b0);
    check("resp_penable_low", PENABLE, 1'b0);
    step();
    check("rsp_valid_one_cycle", rsp_valid, 1'b0);
    check("rsp_err_cleared", rsp_err, 1'b0);
    check("ready_after_resp", req_ready, 1'b1);
  endtask

  int          acc;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_to;
  logic [31:0] b2b_addr [3];
  int          acc_cyc [3];
  int          n_acc;
  int          n_rsp;
  int          n_setup;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    b2b_addr[0] = 32'h4000_0000; b2b_addr[1] = 32'h4000_0004; b2b_addr[2] = 32'h4000_0008;

    // reset state
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_psel", PSEL, 1'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1'b1);
    @(negedge clk);

    // 1: plain write, PREADY at first ACCESS cycle
    run_xfer(1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 1'b0, acc, r_rdata, r_err, r_to);
    check("t1_access_cycles", acc, 1);
    check("t1_rsp_err", r_err, 1'b0);
    check("t1_rsp_timeout", r_to, 1'b0);
    check("t1_rsp_rdata", r_rdata, 32'h0);
    check("t1_pwdata_held", PWDATA, 32'hDEAD_BEEF);

    // 2: read with 3 wait states
    run_xfer(1'b0, 32'h8000_0010, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0, acc, r_rdata, r_err, r_to);
    check("t2_access_cycles", acc, 4);
    check("t2_rsp_rdata", r_rdata, 32'h1234_5678);
    check("t2_rsp_err", r_err, 1'b0);
    check("t2_rsp_timeout", r_to, 1'b0);

    // 3: read against a slave that never answers
    run_xfer(1'b0, 32'h8000_0020, 32'h0, 1000, 32'hCAFE_F00D, 1'b0, 1'b0, acc, r_rdata, r_err, r_to);
    check("t3_access_cycles", acc, 16);
    check("t3_rsp_err", r_err, 1'b1);
    check("t3_rsp_timeout", r_to, 1'b1);
    check("t3_rsp_rdata", r_rdata, 32'h0);

    // 4a: slave error on the ready cycle
    run_xfer(1'b1, 32'h8000_0030, 32'h0000_00A5, 0, 32'h0, 1'b1, 1'b0, acc, r_rdata, r_err, r_to);
    check("t4a_rsp_err", r_err, 1'b1);
    check("t4a_rsp_timeout", r_to, 1'b0);
    // 4b: PSLVERR only during wait states must be ignored
    run_xfer(1'b1, 32'h8000_0034, 32'h0000_005A, 2, 32'h0, 1'b0, 1'b1, acc, r_rdata, r_err, r_to);
    check("t4b_access_cycles", acc, 3);
    check("t4b_rsp_err", r_err, 1'b0);

    // 5: req_valid held high across three back-to-back requests
    n_acc = 0; n_rsp = 0; n_setup = 0;
    PREADY = 1'b1; PRDATA = 32'h0000_1111;
    req_valid = 1'b1; req_write = 1'b0; req_addr = b2b_addr[0];
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (rsp_valid) n_rsp++;
      if (PSEL && !PENABLE) begin
        if (n_setup < 3) check("t5_setup_paddr", PADDR, b2b_addr[n_setup]);
        n_setup++;
      end
      if (req_valid && req_ready) begin
        if (n_acc < 3) acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      step();
      if (n_acc >= 3) req_valid = 1'b0;
      else req_addr = b2b_addr[n_acc];
    end
    PREADY = 1'b0;
    check("t5_accepts", n_acc, 3);
    check("t5_setups", n_setup, 3);
    check("t5_responses", n_rsp, 3);
    check("t5_gap_0_1", acc_cyc[1] - acc_cyc[0], 4);
    check("t5_gap_1_2", acc_cyc[2] - acc_cyc[1], 4);

    // 6: reset during ACCESS
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0040; PREADY = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    check("t6_in_access_psel", PSEL, 1'b1);
    check("t6_in_access_penable", PENABLE, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_psel", PSEL, 1'b0);
    check("t6_rst_penable", PENABLE, 1'b0);
    check("t6_rst_req_ready", req_ready, 1'b0);
    PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_rsp_in_rst", rsp_valid, 1'b0);
    end
    rst = 1'b0;
    #1;
    check("t6_ready_after_rst", req_ready, 1'b1);
    check("t6_no_rsp_after_rst", rsp_valid, 1'b0);
    @(negedge clk);
    check("t6_no_rsp_later", rsp_valid, 1'b0);
    PREADY = 1'b0;

    // recovery: a normal read after the reset
    run_xfer(1'b0, 32'h8000_0044, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0, acc, r_rdata, r_err, r_to);
    check("t6_recover_rdata", r_rdata, 32'h0BAD_F00D);
    check("t6_recover_access_cycles", acc, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
